// File: rtl/gelato_pkg.sv
// Shared types and default sizing for the Gelato frontend warp scheduler.
package gelato_pkg;
    localparam int GELATO_NUM_WARPS = 8;
    localparam int GELATO_PC_WIDTH  = 32;
    localparam int GELATO_THREADS   = 32;
    localparam int GELATO_WARP_ID_W = $clog2(GELATO_NUM_WARPS);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        READY   = 2'd1,
        READING = 2'd2,
        PENDING = 2'd3
    } warp_state_e;

    typedef logic [GELATO_WARP_ID_W-1:0] warp_id_t;

    typedef struct packed {
        warp_id_t                    warp_id;
        logic [GELATO_PC_WIDTH-1:0]  pc;
        logic [GELATO_THREADS-1:0]   mask;
    } fetch_entry_t;
endpackage

// File: rtl/gelato_rr_arbiter.sv
// Combinational round-robin pick: first set request at or after ptr, wrapping.
module gelato_rr_arbiter
    import gelato_pkg::*;
#(
    parameter int NUM_WARPS = GELATO_NUM_WARPS,
    localparam int ID_W     = $clog2(NUM_WARPS)
) (
    input  logic [NUM_WARPS-1:0] req,
    input  logic [ID_W-1:0]      ptr,
    output logic [NUM_WARPS-1:0] grant,
    output logic [ID_W-1:0]      grant_id,
    output logic                 grant_valid
);

    logic [ID_W-1:0] idx;

    always_comb begin
        grant       = '0;
        grant_id    = '0;
        grant_valid = 1'b0;
        idx         = '0;
        for (int k = 0; k < NUM_WARPS; k++) begin
            // NUM_WARPS is a power of two, so the add wraps modulo NUM_WARPS
            idx = ptr + ID_W'(k);
            if (!grant_valid && req[idx]) begin
                grant_valid = 1'b1;
                grant_id    = idx;
                grant[idx]  = 1'b1;
            end
        end
    end

endmodule

// File: rtl/gelato_warp_scheduler.sv
// Round-robin warp scheduler: issues PC table reads for ready warps and
// buffers the responses in a 2-entry FIFO toward instruction fetch.
module gelato_warp_scheduler
    import gelato_pkg::*;
#(
    parameter int NUM_WARPS = GELATO_NUM_WARPS,
    parameter int PC_WIDTH  = GELATO_PC_WIDTH,
    parameter int THREADS   = GELATO_THREADS,
    localparam int ID_W     = $clog2(NUM_WARPS)
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                rdy,
    input  logic                launch_valid,
    input  logic [ID_W-1:0]     launch_warp_id,
    output logic                launch_ready,
    output logic                pc_req_valid,
    output logic [ID_W-1:0]     pc_req_warp_id,
    input  logic                pc_rsp_valid,
    input  logic [PC_WIDTH-1:0] pc_rsp_pc,
    input  logic [THREADS-1:0]  pc_rsp_mask,
    output logic                fetch_valid,
    input  logic                fetch_ready,
    output logic [ID_W-1:0]     fetch_warp_id,
    output logic [PC_WIDTH-1:0] fetch_pc,
    output logic [THREADS-1:0]  fetch_mask,
    input  logic                done_valid,
    input  logic [ID_W-1:0]     done_warp_id,
    input  logic                exit_valid,
    input  logic [ID_W-1:0]     exit_warp_id
);

    typedef struct packed {
        logic [ID_W-1:0]     warp_id;
        logic [PC_WIDTH-1:0] pc;
        logic [THREADS-1:0]  mask;
    } entry_t;

    warp_state_e          wstate_q [NUM_WARPS];
    warp_state_e          wstate_d [NUM_WARPS];
    logic [NUM_WARPS-1:0] arb_req;
    logic [NUM_WARPS-1:0] arb_grant;
    logic [ID_W-1:0]      arb_id;
    logic                 arb_valid;
    logic [ID_W-1:0]      ptr_q;
    logic                 inflight_q;
    logic [ID_W-1:0]      req_id_q;
    entry_t               mem_q [2];
    entry_t               head;
    logic                 wr_q;
    logic                 rd_q;
    logic [1:0]           count_q;
    logic                 push;
    logic                 pop;
    logic                 launch_hs;
    logic [2:0]           occ;
    logic                 credit_ok;

    assign push      = rdy && pc_rsp_valid;
    assign pop       = rdy && fetch_valid && fetch_ready;
    assign launch_hs = launch_valid && launch_ready;

    // A pop in this cycle frees its slot for a grant in the same cycle
    assign occ       = {2'b00, inflight_q} + {1'b0, count_q} - {2'b00, pop};
    assign credit_ok = (occ < 3'd2);

    assign launch_ready = (wstate_q[launch_warp_id] == IDLE);

    always_comb begin
        arb_req = '0;
        for (int i = 0; i < NUM_WARPS; i++) begin
            arb_req[i] = rdy && credit_ok && (wstate_q[i] == READY) &&
                         !(exit_valid && (exit_warp_id == ID_W'(i)));
        end
    end

    gelato_rr_arbiter #(.NUM_WARPS(NUM_WARPS)) u_arb (
        .req        (arb_req),
        .ptr        (ptr_q),
        .grant      (arb_grant),
        .grant_id   (arb_id),
        .grant_valid(arb_valid)
    );

    assign pc_req_valid   = arb_valid;
    assign pc_req_warp_id = arb_id;

    always_comb begin
        for (int i = 0; i < NUM_WARPS; i++) begin
            wstate_d[i] = wstate_q[i];
            if (rdy) begin
                if (exit_valid && (exit_warp_id == ID_W'(i))) begin
                    wstate_d[i] = IDLE;
                end else begin
                    case (wstate_q[i])
                        IDLE:    if (launch_hs && (launch_warp_id == ID_W'(i))) wstate_d[i] = READY;
                        READY:   if (arb_grant[i]) wstate_d[i] = READING;
                        READING: if (push && (req_id_q == ID_W'(i))) wstate_d[i] = PENDING;
                        PENDING: if (done_valid && (done_warp_id == ID_W'(i))) wstate_d[i] = READY;
                        default: wstate_d[i] = IDLE;
                    endcase
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_WARPS; i++) wstate_q[i] <= IDLE;
            ptr_q      <= '0;
            inflight_q <= 1'b0;
            req_id_q   <= '0;
            wr_q       <= 1'b0;
            rd_q       <= 1'b0;
            count_q    <= 2'd0;
        end else if (rdy) begin
            for (int i = 0; i < NUM_WARPS; i++) wstate_q[i] <= wstate_d[i];
            inflight_q <= arb_valid;
            if (arb_valid) begin
                ptr_q    <= arb_id + 1'b1;
                req_id_q <= arb_id;
            end
            if (push) wr_q <= ~wr_q;
            if (pop)  rd_q <= ~rd_q;
            count_q <= count_q + {1'b0, push} - {1'b0, pop};
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem_q[wr_q] <= '{warp_id: req_id_q, pc: pc_rsp_pc, mask: pc_rsp_mask};
    end

    assign head          = mem_q[rd_q];
    assign fetch_valid   = (count_q != 2'd0);
    assign fetch_warp_id = fetch_valid ? head.warp_id : '0;
    assign fetch_pc      = fetch_valid ? head.pc      : '0;
    assign fetch_mask    = fetch_valid ? head.mask    : '0;

    // Responses must pair with a request, and credit must prevent overflow
    always @(posedge clk) begin
        if (rst_n && rdy) begin
            assert (!(pc_rsp_valid && !inflight_q));
            assert (!(push && !pop && (count_q == 2'd2)));
        end
    end

endmodule

// File: tb/tb_gelato_warp_scheduler.sv
// Directed bench with a PC table model and a fetch scoreboard for gelato_warp_scheduler.
module tb_gelato_warp_scheduler;
    localparam int NW = 8;
    localparam int PW = 32;
    localparam int TH = 32;
    localparam int IW = 3;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          rdy;
    logic          launch_valid;
    logic [IW-1:0] launch_warp_id;
    logic          launch_ready;
    logic          pc_req_valid;
    logic [IW-1:0] pc_req_warp_id;
    logic          pc_rsp_valid;
    logic [PW-1:0] pc_rsp_pc;
    logic [TH-1:0] pc_rsp_mask;
    logic          fetch_valid;
    logic          fetch_ready;
    logic [IW-1:0] fetch_warp_id;
    logic [PW-1:0] fetch_pc;
    logic [TH-1:0] fetch_mask;
    logic          done_valid;
    logic [IW-1:0] done_warp_id;
    logic          exit_valid;
    logic [IW-1:0] exit_warp_id;

    always #5 clk = ~clk;

    gelato_warp_scheduler #(.NUM_WARPS(NW), .PC_WIDTH(PW), .THREADS(TH)) dut (
        .clk(clk), .rst_n(rst_n), .rdy(rdy),
        .launch_valid(launch_valid), .launch_warp_id(launch_warp_id), .launch_ready(launch_ready),
        .pc_req_valid(pc_req_valid), .pc_req_warp_id(pc_req_warp_id),
        .pc_rsp_valid(pc_rsp_valid), .pc_rsp_pc(pc_rsp_pc), .pc_rsp_mask(pc_rsp_mask),
        .fetch_valid(fetch_valid), .fetch_ready(fetch_ready), .fetch_warp_id(fetch_warp_id),
        .fetch_pc(fetch_pc), .fetch_mask(fetch_mask),
        .done_valid(done_valid), .done_warp_id(done_warp_id),
        .exit_valid(exit_valid), .exit_warp_id(exit_warp_id)
    );

    typedef struct packed {
        logic [IW-1:0] id;
        logic [PW-1:0] pc;
        logic [TH-1:0] mask;
    } ent_t;

    ent_t          sb [$];
    logic [IW-1:0] glog [$];
    logic [PW-1:0] tb_pc [NW];
    logic [TH-1:0] tb_mask [NW];
    logic          rsp_pend;
    logic [IW-1:0] rsp_id;
    logic          popped;
    logic [IW-1:0] last_pop_id;
    int            n_pops;
    int            n_tests = 0;
    int            n_fail  = 0;
    int            rr_exp [6] = '{0, 2, 5, 0, 2, 5};
    int            bp_exp [4] = '{0, 1, 2, 3};
    int            st_exp [4] = '{0, 1, 3, 5};
    int            pops_before;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One clock: sample before the edge, then model the PC table 1 cycle later.
    task automatic tick();
        logic          s_rdy, s_req, s_rsp;
        logic [IW-1:0] s_req_id;
        ent_t          e;
        #1;
        s_rdy    = rdy;
        s_req    = pc_req_valid;
        s_req_id = pc_req_warp_id;
        s_rsp    = pc_rsp_valid;
        popped   = 1'b0;
        if (rdy && fetch_valid && fetch_ready) begin
            if (sb.size() == 0) begin
                chk("sb_underflow", 64'd1, 64'd0);
            end else begin
                e = sb.pop_front();
                chk("fetch_id", 64'(fetch_warp_id), 64'(e.id));
                chk("fetch_pc", 64'(fetch_pc), 64'(e.pc));
                chk("fetch_mask", 64'(fetch_mask), 64'(e.mask));
            end
            popped      = 1'b1;
            last_pop_id = fetch_warp_id;
            n_pops++;
        end
        if (s_rdy && s_req) glog.push_back(s_req_id);
        if (s_rdy && s_rsp) begin
            e.id   = rsp_id;
            e.pc   = tb_pc[rsp_id];
            e.mask = tb_mask[rsp_id];
            sb.push_back(e);
            tb_pc[rsp_id] = tb_pc[rsp_id] + 32'd4;
        end
        @(posedge clk);
        #1;
        if (s_rdy) begin
            rsp_pend = s_req;
            if (s_req) rsp_id = s_req_id;
        end
        pc_rsp_valid = rsp_pend;
        pc_rsp_pc    = rsp_pend ? tb_pc[rsp_id]   : '0;
        pc_rsp_mask  = rsp_pend ? tb_mask[rsp_id] : '0;
        launch_valid = 1'b0;
        done_valid   = 1'b0;
        exit_valid   = 1'b0;
        #1;
    endtask

    task automatic clear_inputs();
        rdy = 1'b1; launch_valid = 1'b0; launch_warp_id = '0; fetch_ready = 1'b0;
        done_valid = 1'b0; done_warp_id = '0; exit_valid = 1'b0; exit_warp_id = '0;
        pc_rsp_valid = 1'b0; pc_rsp_pc = '0; pc_rsp_mask = '0;
        rsp_pend = 1'b0; rsp_id = '0; popped = 1'b0; last_pop_id = '0; n_pops = 0;
        sb.delete();
        glog.delete();
        for (int i = 0; i < NW; i++) begin
            tb_pc[i]   = 32'h1000 + 32'(i) * 32'h100;
            tb_mask[i] = 32'hA5A5_0000 | 32'(i + 1);
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        clear_inputs();
        @(posedge clk);
        @(posedge clk);
        #1 rst_n = 1'b1;
        #1;
    endtask

    task automatic launch(input int id);
        launch_valid   = 1'b1;
        launch_warp_id = IW'(id);
        tick();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset values
        rst_n = 1'b0;
        clear_inputs();
        #2;
        chk("rst_launch_ready", 64'(launch_ready), 64'd1);
        chk("rst_pc_req_valid", 64'(pc_req_valid), 64'd0);
        chk("rst_fetch_valid", 64'(fetch_valid), 64'd0);
        chk("rst_fetch_pc", 64'(fetch_pc), 64'd0);
        chk("rst_fetch_mask", 64'(fetch_mask), 64'd0);
        chk("rst_fetch_id", 64'(fetch_warp_id), 64'd0);

        // Reset mid-stream
        do_reset();
        launch(0);
        launch(1);
        tick();
        tick();
        launch_warp_id = 3'd1;
        #1;
        chk("mid_fetch_valid_pre", 64'(fetch_valid), 64'd1);
        chk("mid_launch_ready_pre", 64'(launch_ready), 64'd0);
        rst_n = 1'b0;
        rsp_pend = 1'b0;
        pc_rsp_valid = 1'b0;
        #1;
        chk("mid_pc_req_valid", 64'(pc_req_valid), 64'd0);
        chk("mid_fetch_valid", 64'(fetch_valid), 64'd0);
        chk("mid_launch_ready", 64'(launch_ready), 64'd1);
        chk("mid_fetch_pc", 64'(fetch_pc), 64'd0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        sb.delete();
        glog.delete();
        #1;
        launch(0);
        chk("mid_relaunch_req", 64'(pc_req_valid), 64'd1);
        chk("mid_relaunch_id", 64'(pc_req_warp_id), 64'd0);

        // Single warp latency and one-outstanding rule
        do_reset();
        fetch_ready = 1'b1;
        tb_pc[3]   = 32'h0000_0100;
        tb_mask[3] = 32'hFFFF_FFFF;
        launch(3);
        chk("sw_c1_req", 64'(pc_req_valid), 64'd1);
        chk("sw_c1_id", 64'(pc_req_warp_id), 64'd3);
        tick();
        chk("sw_c2_req", 64'(pc_req_valid), 64'd0);
        chk("sw_c2_fetch_valid", 64'(fetch_valid), 64'd0);
        tick();
        chk("sw_c3_fetch_valid", 64'(fetch_valid), 64'd1);
        chk("sw_c3_id", 64'(fetch_warp_id), 64'd3);
        chk("sw_c3_pc", 64'(fetch_pc), 64'h100);
        chk("sw_c3_mask", 64'(fetch_mask), 64'hFFFF_FFFF);
        tick();
        for (int c = 0; c < 4; c++) begin
            chk("sw_no_second_req", 64'(pc_req_valid), 64'd0);
            tick();
        end
        chk("sw_grants", 64'(glog.size()), 64'd1);
        done_valid = 1'b1;
        done_warp_id = 3'd3;
        tick();
        chk("sw_after_done_req", 64'(pc_req_valid), 64'd1);
        chk("sw_after_done_id", 64'(pc_req_warp_id), 64'd3);
        repeat (4) tick();
        chk("sw_sb_empty", 64'(sb.size()), 64'd0);

        // Round robin over warps 0,2,5
        do_reset();
        fetch_ready = 1'b1;
        launch(0);
        launch(2);
        launch(5);
        for (int c = 0; c < 60 && glog.size() < 6; c++) begin
            if (popped) begin
                done_valid   = 1'b1;
                done_warp_id = last_pop_id;
            end
            tick();
        end
        chk("rr_count", 64'(glog.size()), 64'd6);
        for (int i = 0; i < glog.size() && i < 6; i++) chk("rr_order", 64'(glog[i]), 64'(rr_exp[i]));
        repeat (5) tick();
        chk("rr_sb_empty", 64'(sb.size()), 64'd0);

        // Backpressure with four ready warps
        do_reset();
        launch(0);
        launch(1);
        launch(2);
        launch(3);
        repeat (4) tick();
        chk("bp_two_reqs", 64'(glog.size()), 64'd2);
        chk("bp_req_held", 64'(pc_req_valid), 64'd0);
        chk("bp_fetch_valid", 64'(fetch_valid), 64'd1);
        chk("bp_head", 64'(fetch_warp_id), 64'd0);
        fetch_ready = 1'b1;
        #1;
        chk("bp_pop_grant", 64'(pc_req_valid), 64'd1);
        chk("bp_pop_grant_id", 64'(pc_req_warp_id), 64'd2);
        tick();
        fetch_ready = 1'b0;
        #1;
        chk("bp_no_credit_a", 64'(pc_req_valid), 64'd0);
        tick();
        chk("bp_no_credit_b", 64'(pc_req_valid), 64'd0);
        fetch_ready = 1'b1;
        #1;
        chk("bp_pop_grant2", 64'(pc_req_valid), 64'd1);
        chk("bp_pop_grant2_id", 64'(pc_req_warp_id), 64'd3);
        repeat (6) tick();
        chk("bp_pops", 64'(n_pops), 64'd4);
        chk("bp_grants", 64'(glog.size()), 64'd4);
        for (int i = 0; i < glog.size() && i < 4; i++) chk("bp_order", 64'(glog[i]), 64'(bp_exp[i]));
        chk("bp_sb_empty", 64'(sb.size()), 64'd0);

        // Exit and done on the same warp in the same cycle
        do_reset();
        fetch_ready = 1'b1;
        launch(1);
        repeat (3) tick();
        launch_warp_id = 3'd1;
        #1;
        chk("ex_pending_busy", 64'(launch_ready), 64'd0);
        done_valid = 1'b1; done_warp_id = 3'd1;
        exit_valid = 1'b1; exit_warp_id = 3'd1;
        tick();
        chk("ex_idle", 64'(launch_ready), 64'd1);
        chk("ex_no_req", 64'(pc_req_valid), 64'd0);
        done_valid = 1'b1; done_warp_id = 3'd1;
        tick();
        chk("ex_done_ignored", 64'(launch_ready), 64'd1);
        chk("ex_done_ignored_req", 64'(pc_req_valid), 64'd0);

        // rdy stall with an entry ready to pop and warps waiting
        do_reset();
        launch(0);
        launch(1);
        launch(3);
        launch(5);
        repeat (3) tick();
        fetch_ready = 1'b1;
        rdy = 1'b0;
        pops_before = n_pops;
        launch_valid = 1'b1;
        launch_warp_id = 3'd6;
        for (int c = 0; c < 3; c++) begin
            #1;
            chk("st_no_req", 64'(pc_req_valid), 64'd0);
            chk("st_fetch_valid", 64'(fetch_valid), 64'd1);
            chk("st_head", 64'(fetch_warp_id), 64'd0);
            tick();
        end
        chk("st_no_pop", 64'(n_pops), 64'(pops_before));
        launch_warp_id = 3'd6;
        rdy = 1'b1;
        #1;
        chk("st_launch_frozen", 64'(launch_ready), 64'd1);
        chk("st_resume_req", 64'(pc_req_valid), 64'd1);
        chk("st_resume_id", 64'(pc_req_warp_id), 64'd3);
        tick();
        chk("st_next_id", 64'(pc_req_warp_id), 64'd5);
        repeat (6) tick();
        chk("st_grants", 64'(glog.size()), 64'd4);
        for (int i = 0; i < glog.size() && i < 4; i++) chk("st_order", 64'(glog[i]), 64'(st_exp[i]));
        chk("st_sb_empty", 64'(sb.size()), 64'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/gelato_warp_scheduler.md
# gelato_warp_scheduler

Round-robin warp scheduler in the Gelato frontend. It sequences the split table's PC table read port: it picks one ready warp per cycle and reads that warp's current PC and active mask. It then buffers the result and presents it to instruction fetch. It tracks per-warp lifecycle (launch, in-flight, resolved, exit) so that each warp has at most one instruction outstanding in the frontend.

## Interface
Parameters:
- NUM_WARPS, 8, number of hardware warps (power of two, ≥2)
- PC_WIDTH, 32, program counter width
- THREADS, 32, threads per warp (active-mask width)

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- rdy  in  1  global enable; low freezes all state
- launch_valid  in  1  activate a warp
- launch_warp_id  in  log2(NUM_WARPS)  warp to activate
- launch_ready  out  1  target warp is IDLE
- pc_req_valid  out  1  PC table read request
- pc_req_warp_id  out  log2(NUM_WARPS)  warp being read
- pc_rsp_valid  in  1  PC table response, exactly 1 cycle after request
- pc_rsp_pc  in  PC_WIDTH  warp PC
- pc_rsp_mask  in  THREADS  warp active mask
- fetch_valid  out  1  entry available to fetch
- fetch_ready  in  1  fetch accepts entry
- fetch_warp_id / fetch_pc / fetch_mask  out  log2(NUM_WARPS) / PC_WIDTH / THREADS  entry payload
- done_valid, done_warp_id  in  1, log2(NUM_WARPS)  warp's instruction resolved, PC table updated
- exit_valid, exit_warp_id  in  1, log2(NUM_WARPS)  warp terminated

## Operation
- Each warp has a state: IDLE, READY, READING, PENDING.
- IDLE→READY on launch handshake (launch_valid & launch_ready).
- READY→READING when granted; pc_req is issued that cycle.
- READING→PENDING when pc_rsp is written into the output buffer.
- PENDING→READY on done_valid.
- Any state→IDLE on exit_valid.
- exit and done for the same warp in the same cycle: exit wins.
- launch to a non-IDLE warp: launch_ready=0, no effect.
- done to a non-PENDING warp: ignored.
- Grant: round-robin over READY warps, searching from pointer; pointer = granted id + 1 (mod NUM_WARPS).
- A grant requires credit: in-flight reads + buffered entries < 2.
- Output buffer: 2-entry FIFO of {warp_id, pc, mask}.
  - fetch_* shows the head entry.
  - Pop on fetch_valid & fetch_ready.
  - Push on pc_rsp_valid.
  - Push and pop in the same cycle are allowed when full.
- A pc_rsp_valid with no outstanding request is a protocol error; assert in simulation.
- rdy=0:
  - No state, pointer or FIFO update.
  - pc_req_valid=0.
  - fetch_valid holds its value, but no transfer occurs.
  - The PC table is stalled by the same rdy, so no pc_rsp arrives.
- Reset (async, any time): all warps IDLE, FIFO empty, pointer 0, in-flight cleared.

## Timing
- Reset values: launch_ready=1, pc_req_valid=0, fetch_valid=0; fetch payload 0.
- launch_ready is combinational on launch_warp_id and state.
- Launch accepted at cycle 0 → warp READY in cycle 1 → pc_req in cycle 1 → pc_rsp in cycle 2 → fetch_valid in cycle 3.
- done at cycle N → warp READY in cycle N+1 → eligible for grant in cycle N+1.
- Throughput: 1 entry/cycle sustained with ≥2 ready warps and fetch_ready held high.
- With fetch_ready low: at most 2 requests are issued, then pc_req_valid=0 until a pop.
- A pop frees credit the same cycle: a grant may fire in the cycle of the pop.

## Structure
- gelato_pkg holds:
  - warp_state_e (IDLE/READY/READING/PENDING)
  - warp_id_t
  - fetch_entry_t {warp_id, pc, mask}
  - default NUM_WARPS/THREADS constants
- Sub-module gelato_rr_arbiter: NUM_WARPS request vector plus pointer in, one-hot grant plus id out; combinational, with the pointer held in the scheduler.
- The FIFO is inline (2 entries, registered).

## Test plan
- Reset mid-stream: launch warps 0,1, assert rst_n=0 at cycle 4 → all outputs return to reset values; first grant after relaunch is warp 0.
- Single warp: launch warp 3, respond pc=0x100, mask=0xFFFFFFFF, fetch_ready=1 → fetch_valid at cycle 3 with {3, 0x100, 0xFFFFFFFF}; no second request until done_warp_id=3.
- Round robin: launch warps 0,2,5; issue done for each warp after its fetch → grant order 0,2,5,0,2,5.
- Backpressure: 4 ready warps, fetch_ready=0 → exactly 2 pc_req, then pc_req_valid=0; raise fetch_ready → one grant per pop, FIFO order preserved.
- Exit/done collision: warp 1 PENDING; done_warp_id=1 and exit_warp_id=1 in the same cycle → warp 1 IDLE; launch_ready=1 for warp 1.
- rdy stall: deassert rdy for 3 cycles with fetch_valid=1 and fetch_ready=1 → no pop, no grant, no pointer move; resume identically when rdy returns high.
